// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory access path.
//   BYTE/HALFWORD/WORD  access-size encodings used on req_size and mem_size
//   MEM_BAD_DATA        load data returned for a blocked access
//   state_e             access FSM state encoding
//   size_bytes()        access size in bytes (unknown encodings treated as a word)
package mem_if_pkg;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  localparam logic [31:0] MEM_BAD_DATA = 32'hBADB_ADFF;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBeat = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      BYTE:     size_bytes = 3'd1;
      HALFWORD: size_bytes = 3'd2;
      default:  size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// Request/response handshake plus data-memory port of the memory access master.
//   req_*   load/store request from the MEM stage (valid/ready)
//   resp_*  single-cycle completion pulse with load data and error flag
//   mem_*   byte-addressed memory port; mem_rdata is combinational from the memory
// Modports: master = the access block, slave = MEM stage + memory side.
interface mem_access_master_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_rdun;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_we, mem_size, mem_rdun
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, req_size, req_unsigned, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_we, mem_size, mem_rdun
  );

endinterface

// File: rtl/mem_lane_assembler.sv
// Combinational byte-lane assembler for split loads.
//   acc_i       bytes gathered so far
//   byte_i      byte returned by the current beat
//   lane_i      lane the current byte belongs in
//   size_i      original access size, selects the extension point
//   unsigned_i  1: zero-extend, 0: sign-extend
//   placed_o    acc_i with byte_i written into lane_i
//   ext_o       acc_i extended from bit 7 (byte), bit 15 (halfword) or unchanged (word)
module mem_lane_assembler
  import mem_if_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] placed_o,
  output logic [31:0] ext_o
);

  logic sext;

  always_comb begin
    placed_o = acc_i;
    placed_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

  always_comb begin
    sext = ~unsigned_i;
    case (size_i)
      BYTE:     ext_o = {{24{sext & acc_i[7]}}, acc_i[7:0]};
      HALFWORD: ext_o = {{16{sext & acc_i[15]}}, acc_i[15:0]};
      default:  ext_o = acc_i;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// Initiator side of the byte-addressed data-memory port.
// Accepts one load/store at a time, issues one beat for aligned accesses or one byte beat per
// byte for misaligned ones, reassembles split loads, and blocks out-of-window accesses.
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus_io   request/response/memory port bundle (master modport)
// Parameters: MEM_BASE/MEM_SIZE define the valid window [MEM_BASE, MEM_BASE+MEM_SIZE);
// ALLOW_MISALIGNED selects splitting (1) or rejecting (0) misaligned accesses.
module mem_access_master
  import mem_if_pkg::*;
#(
  parameter logic [31:0] MEM_BASE         = 32'h0100_0000,
  parameter logic [31:0] MEM_SIZE         = 32'h0010_0000,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  mem_access_master_if.master        bus_io
);

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [2:0]  nbeats_q;
  logic        split_q;
  logic        err_q;
  logic [31:0] acc_q;

  logic        load_req;
  logic        capture;

  // Request decode, only meaningful in the accept cycle.
  logic [2:0]  req_bytes;
  logic [32:0] req_lo, req_hi, win_lo, win_hi;
  logic        out_of_win, misaligned, acc_err;
  logic [2:0]  acc_nbeats;

  logic [31:0] asm_placed, asm_ext;

  always_comb begin
    req_bytes  = size_bytes(bus_io.req_size);
    // 33-bit bounds so an access wrapping past 2^32 lands above the window.
    req_lo     = {1'b0, bus_io.req_addr};
    req_hi     = req_lo + {30'd0, req_bytes} - 33'd1;
    win_lo     = {1'b0, MEM_BASE};
    win_hi     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    out_of_win = (req_lo < win_lo) || (req_hi >= win_hi);
    misaligned = ((req_bytes == 3'd2) && bus_io.req_addr[0]) ||
                 ((req_bytes == 3'd4) && (bus_io.req_addr[1:0] != 2'b00));
    acc_err    = out_of_win || (misaligned && !ALLOW_MISALIGNED);
    acc_nbeats = misaligned ? req_bytes : 3'd1;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    load_req = 1'b0;
    capture  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.req_valid && reset_n) begin
          load_req = 1'b1;
          beat_d   = 2'd0;
          state_d  = acc_err ? StDone : StBeat;
        end
      end
      StBeat: begin
        capture = 1'b1;
        if ({1'b0, beat_q} == nbeats_q - 3'd1) begin
          state_d = StDone;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Request registers and load-data accumulator.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      write_q  <= 1'b0;
      size_q   <= WORD;
      uns_q    <= 1'b0;
      nbeats_q <= 3'd1;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= 32'd0;
    end else begin
      if (load_req) begin
        addr_q   <= bus_io.req_addr;
        wdata_q  <= bus_io.req_wdata;
        write_q  <= bus_io.req_write;
        size_q   <= bus_io.req_size;
        uns_q    <= bus_io.req_unsigned;
        nbeats_q <= acc_nbeats;
        split_q  <= (acc_nbeats != 3'd1);
        err_q    <= acc_err;
        acc_q    <= 32'd0;
      end else if (capture) begin
        acc_q <= split_q ? asm_placed : bus_io.mem_rdata;
      end
    end
  end

  mem_lane_assembler u_lane_asm (
    .acc_i      (acc_q),
    .byte_i     (bus_io.mem_rdata[7:0]),
    .lane_i     (beat_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .placed_o   (asm_placed),
    .ext_o      (asm_ext)
  );

  // Outputs decode from registered state only; the memory port idles outside BEAT.
  // The memory port is not gated by reset_n so a write beat in the reset cycle still commits.
  always_comb begin
    bus_io.req_ready  = (state_q == StIdle) && reset_n;
    bus_io.mem_addr   = 32'd0;
    bus_io.mem_wdata  = 32'd0;
    bus_io.mem_we     = 1'b0;
    bus_io.mem_size   = WORD;
    bus_io.mem_rdun   = 1'b0;
    bus_io.resp_valid = 1'b0;
    bus_io.resp_err   = 1'b0;
    bus_io.resp_rdata = 32'd0;

    if (state_q == StBeat) begin
      bus_io.mem_we = write_q;
      if (split_q) begin
        bus_io.mem_addr  = addr_q + {30'd0, beat_q};
        bus_io.mem_size  = BYTE;
        bus_io.mem_rdun  = 1'b1;
        bus_io.mem_wdata = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
      end else begin
        bus_io.mem_addr  = addr_q;
        bus_io.mem_size  = size_q;
        bus_io.mem_rdun  = uns_q;
        bus_io.mem_wdata = wdata_q;
      end
    end

    if ((state_q == StDone) && reset_n) begin
      bus_io.resp_valid = 1'b1;
      bus_io.resp_err   = err_q;
      if (err_q) begin
        bus_io.resp_rdata = MEM_BAD_DATA;
      end else if (!write_q) begin
        // Aligned loads are extended by the memory itself.
        bus_io.resp_rdata = split_q ? asm_ext : acc_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: a default instance and one with misalignment rejected,
// sharing a behavioural byte memory covering the valid window.
module tb_mem_access_master;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_master_if mif0 ();
  mem_access_master_if mif1 ();

  mem_access_master u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (mif0)
  );

  mem_access_master #(
    .ALLOW_MISALIGNED (1'b0)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (mif1)
  );

  // Behavioural memory: 1 MiB window, little-endian, combinational read with extension.
  logic [7:0]  mem [0:1048575];
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = 32'd0;
  logic [7:0]  poke_data = 8'd0;

  function automatic bit inwin(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0010_0000);
  endfunction

  function automatic logic [19:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d[19:0];
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
  endfunction

  function automatic logic [7:0] mget(input logic [31:0] a);
    return inwin(a) ? mem[widx(a)] : 8'h00;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] s,
                                         input logic un);
    logic [7:0] b0, b1, b2, b3;
    b0 = mget(a);
    b1 = mget(a + 32'd1);
    b2 = mget(a + 32'd2);
    b3 = mget(a + 32'd3);
    if (s == SZ_B) return un ? {24'd0, b0} : {{24{b0[7]}}, b0};
    if (s == SZ_H) return un ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    for (int i = 0; i < 1048576; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (poke_en) mem[widx(poke_addr)] <= poke_data;
    if (mif0.mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes(mif0.mem_size) && inwin(mif0.mem_addr + 32'(i)))
          mem[widx(mif0.mem_addr + 32'(i))] <= mif0.mem_wdata[8*i +: 8];
      end
    end
    if (mif1.mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes(mif1.mem_size) && inwin(mif1.mem_addr + 32'(i)))
          mem[widx(mif1.mem_addr + 32'(i))] <= mif1.mem_wdata[8*i +: 8];
      end
    end
  end

  always @(negedge clk or mif0.mem_addr or mif0.mem_size or mif0.mem_rdun or
           mif1.mem_addr or mif1.mem_size or mif1.mem_rdun) begin
    mif0.mem_rdata = mem_rd(mif0.mem_addr, mif0.mem_size, mif0.mem_rdun);
    mif1.mem_rdata = mem_rd(mif1.mem_addr, mif1.mem_size, mif1.mem_rdun);
  end

  // View of the instance selected by sel.
  bit          sel = 1'b0;
  logic        v_ready, v_rvalid, v_rerr, v_we;
  logic [31:0] v_rdata, v_addr, v_wdata;
  logic [1:0]  v_size;
  assign v_ready  = sel ? mif1.req_ready  : mif0.req_ready;
  assign v_rvalid = sel ? mif1.resp_valid : mif0.resp_valid;
  assign v_rerr   = sel ? mif1.resp_err   : mif0.resp_err;
  assign v_rdata  = sel ? mif1.resp_rdata : mif0.resp_rdata;
  assign v_we     = sel ? mif1.mem_we     : mif0.mem_we;
  assign v_addr   = sel ? mif1.mem_addr   : mif0.mem_addr;
  assign v_wdata  = sel ? mif1.mem_wdata  : mif0.mem_wdata;
  assign v_size   = sel ? mif1.mem_size   : mif0.mem_size;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] wd, input bit w,
                       input logic [1:0] sz, input bit un);
    if (sel) begin
      mif1.req_valid = v; mif1.req_addr = a; mif1.req_wdata = wd;
      mif1.req_write = w; mif1.req_size = sz; mif1.req_unsigned = un;
    end else begin
      mif0.req_valid = v; mif0.req_addr = a; mif0.req_wdata = wd;
      mif0.req_write = w; mif0.req_size = sz; mif0.req_unsigned = un;
    end
  endtask

  // Results of the last transaction.
  int          lat;
  logic [31:0] r_rdata;
  logic        r_err;
  int          n_beats;
  int          n_we;
  logic [31:0] wbytes;
  logic [31:0] beat_addr [4];
  logic [1:0]  beat_size [4];

  // Latency counts cycles from the accept edge; beats are cycles with a non-zero mem_addr.
  task automatic do_req(input bit s, input logic [31:0] a, input logic [31:0] wd, input bit w,
                        input logic [1:0] sz, input bit un);
    int waitc;
    sel = s;
    lat = -1; r_rdata = 32'd0; r_err = 1'b0; n_beats = 0; n_we = 0; wbytes = 32'd0;
    for (int i = 0; i < 4; i++) begin beat_addr[i] = 32'd0; beat_size[i] = 2'b11; end
    @(negedge clk);
    drive(1'b1, a, wd, w, sz, un);
    waitc = 0;
    while (!v_ready && waitc < 20) begin @(negedge clk); waitc++; end
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 32'd0, 32'd0, 1'b0, SZ_W, 1'b0);
      if (v_addr != 32'd0) begin
        if (n_beats < 4) begin
          beat_addr[n_beats] = v_addr;
          beat_size[n_beats] = v_size;
        end
        if (v_we && n_we < 4) begin
          wbytes[8*n_we +: 8] = v_wdata[7:0];
          n_we++;
        end
        n_beats++;
      end
      if (v_rvalid) begin
        lat = c;
        r_rdata = v_rdata;
        r_err = v_rerr;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, SZ_W, 1'b0);
    sel = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, SZ_W, 1'b0);
    sel = 1'b0;
    reset_n = 1'b0;

    // Preload memory while held in reset.
    poke(BASE + 32'h00, 8'h78);
    poke(BASE + 32'h01, 8'h56);
    poke(BASE + 32'h02, 8'h34);
    poke(BASE + 32'h03, 8'h12);
    poke(BASE + 32'h11, 8'h80);
    poke(BASE + 32'h12, 8'hFF);
    poke(BASE + 32'h34, 8'hEE);

    @(negedge clk);
    chk("rst_req_ready", {31'd0, mif0.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, mif0.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, mif0.resp_err}, 32'd0);
    chk("rst_resp_rdata", mif0.resp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mif0.mem_we}, 32'd0);
    chk("rst_mem_addr", mif0.mem_addr, 32'd0);
    chk("rst_mem_wdata", mif0.mem_wdata, 32'd0);
    chk("rst_mem_size", {30'd0, mif0.mem_size}, {30'd0, SZ_W});
    chk("rst_mem_rdun", {31'd0, mif0.mem_rdun}, 32'd0);

    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, mif0.req_ready}, 32'd1);

    // Aligned LW.
    do_req(1'b0, BASE, 32'd0, 1'b0, SZ_W, 1'b0);
    chk("lw_lat", lat, 32'd2);
    chk("lw_rdata", r_rdata, 32'h1234_5678);
    chk("lw_err", {31'd0, r_err}, 32'd0);
    chk("lw_beats", n_beats, 32'd1);
    chk("lw_beat_size", {30'd0, beat_size[0]}, {30'd0, SZ_W});
    chk("lw_beat_addr", beat_addr[0], BASE);

    // Misaligned LH, signed then unsigned.
    do_req(1'b0, BASE + 32'h11, 32'd0, 1'b0, SZ_H, 1'b0);
    chk("lh_lat", lat, 32'd3);
    chk("lh_beats", n_beats, 32'd2);
    chk("lh_beat0_addr", beat_addr[0], BASE + 32'h11);
    chk("lh_beat1_addr", beat_addr[1], BASE + 32'h12);
    chk("lh_beat0_size", {30'd0, beat_size[0]}, {30'd0, SZ_B});
    chk("lh_rdata", r_rdata, 32'hFFFF_FF80);
    do_req(1'b0, BASE + 32'h11, 32'd0, 1'b0, SZ_H, 1'b1);
    chk("lhu_rdata", r_rdata, 32'h0000_FF80);

    // Misaligned SW then read it back.
    do_req(1'b0, BASE + 32'h23, 32'hAABB_CCDD, 1'b1, SZ_W, 1'b0);
    chk("sw_lat", lat, 32'd5);
    chk("sw_we_beats", n_we, 32'd4);
    chk("sw_bytes", wbytes, 32'hAABB_CCDD);
    chk("sw_rdata", r_rdata, 32'd0);
    chk("sw_mem23", {24'd0, mget(BASE + 32'h23)}, 32'h0000_00DD);
    chk("sw_mem26", {24'd0, mget(BASE + 32'h26)}, 32'h0000_00AA);
    do_req(1'b0, BASE + 32'h23, 32'd0, 1'b0, SZ_W, 1'b0);
    chk("lw_mis_lat", lat, 32'd5);
    chk("lw_mis_rdata", r_rdata, 32'hAABB_CCDD);

    // Out-of-window accesses.
    do_req(1'b0, 32'h0110_0000, 32'd0, 1'b0, SZ_W, 1'b0);
    chk("oow_lw_lat", lat, 32'd1);
    chk("oow_lw_err", {31'd0, r_err}, 32'd1);
    chk("oow_lw_rdata", r_rdata, 32'hBADB_ADFF);
    chk("oow_lw_beats", n_beats, 32'd0);
    do_req(1'b0, 32'h010F_FFFE, 32'h1111_2222, 1'b1, SZ_W, 1'b0);
    chk("oow_sw_lat", lat, 32'd1);
    chk("oow_sw_err", {31'd0, r_err}, 32'd1);
    chk("oow_sw_we", n_we, 32'd0);
    do_req(1'b0, 32'hFFFF_FFFE, 32'd0, 1'b0, SZ_W, 1'b0);
    chk("wrap_err", {31'd0, r_err}, 32'd1);
    chk("wrap_lat", lat, 32'd1);

    // Misalignment rejected on the second instance.
    do_req(1'b1, BASE + 32'h01, 32'd0, 1'b0, SZ_H, 1'b0);
    chk("nomis_lh_err", {31'd0, r_err}, 32'd1);
    chk("nomis_lh_beats", n_beats, 32'd0);
    chk("nomis_lh_lat", lat, 32'd1);
    do_req(1'b1, BASE + 32'h05, 32'h1234_565A, 1'b1, SZ_B, 1'b0);
    chk("nomis_sb_err", {31'd0, r_err}, 32'd0);
    chk("nomis_sb_lat", lat, 32'd2);
    chk("nomis_sb_we", n_we, 32'd1);
    do_req(1'b1, BASE + 32'h05, 32'd0, 1'b0, SZ_B, 1'b1);
    chk("nomis_lbu_rdata", r_rdata, 32'h0000_005A);

    // Reset during beat 2 of a misaligned SW.
    sel = 1'b0;
    @(negedge clk);
    drive(1'b1, BASE + 32'h31, 32'h1122_3344, 1'b1, SZ_W, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, SZ_W, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rstbeat2_we", {31'd0, mif0.mem_we}, 32'd1);
    chk("rstbeat2_addr", mif0.mem_addr, BASE + 32'h33);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstbeat_resp_valid", {31'd0, mif0.resp_valid}, 32'd0);
    chk("rstbeat_we_after", {31'd0, mif0.mem_we}, 32'd0);
    @(negedge clk);
    chk("rstbeat_resp_valid2", {31'd0, mif0.resp_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstbeat_ready", {31'd0, mif0.req_ready}, 32'd1);
    chk("rstbeat_mem31", {24'd0, mget(BASE + 32'h31)}, 32'h0000_0044);
    chk("rstbeat_mem33", {24'd0, mget(BASE + 32'h33)}, 32'h0000_0022);
    chk("rstbeat_mem34", {24'd0, mget(BASE + 32'h34)}, 32'h0000_00EE);
    do_req(1'b0, BASE + 32'h31, 32'd0, 1'b0, SZ_W, 1'b0);
    chk("post_rst_lat", lat, 32'd5);
    chk("post_rst_rdata", r_rdata, 32'hEE22_3344);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
